// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shift engine: generates sclk, shifts a word out on sddo and in from sddi.
// Optional CRC7 over transmitted bits is built only when SPI_SHIFT_CRC7_EN is defined.
module spi_shift_engine #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        line_select,
  input  logic [DATA_W-1:0] command_in,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              lsb_first,
  input  logic              crc_clr,
  input  logic              sddi,
  output logic              sclk,
  output logic              sddo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [6:0]        crc7
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_load;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic              lsb_lat;
  logic              div_last;
  logic              load_bit;
  logic              next_bit;

  // Source 00 re-sends the previously received word.
  always_comb begin
    tx_load = '1;
    case (line_select)
      2'b10:   tx_load = command_in;
      2'b01:   tx_load = fifo_data;
      2'b00:   tx_load = data_out;
      default: tx_load = '1;
    endcase
  end

  assign div_last = (div_cnt == DIV_LAST);
  assign load_bit = lsb_first ? tx_load[0] : tx_load[DATA_W-1];
  assign tx_next  = lsb_lat ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};
  assign next_bit = lsb_lat ? tx_next[0] : tx_next[DATA_W-1];
  assign rx_next  = lsb_lat ? {sddi, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], sddi};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      lsb_lat  <= 1'b0;
      sclk     <= 1'b0;
      sddo     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tx_shift <= tx_load;
            lsb_lat  <= lsb_first;
            rx_shift <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sddo     <= load_bit;
            busy     <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (div_last) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            rx_shift <= rx_next;
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // Falling sclk either shifts to the next bit or finishes the word.
        HIGH: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              sddo     <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              data_out <= rx_shift;
              state    <= DONE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= tx_next;
              sddo     <= next_bit;
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SHIFT_CRC7_EN
  logic tx_bit;
  logic crc_fb;
  logic bit_end;

  assign tx_bit  = lsb_lat ? tx_shift[0] : tx_shift[DATA_W-1];
  assign crc_fb  = tx_bit ^ crc7[6];
  assign bit_end = (state == HIGH) && div_last;

  // SD-card CRC7 (x^7 + x^3 + 1), one step per transmitted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc7 <= '0;
    end else if (crc_clr) begin
      crc7 <= '0;
    end else if (bit_end) begin
      crc7 <= {crc7[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    end
  end
`else
  logic unused_crc_clr;

  assign unused_crc_clr = crc_clr;
  assign crc7           = '0;
`endif

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning transfer word width in bits (legal 4..32).
REQ-002 SHALL provide parameter CLK_DIV, default 4, meaning sclk half-period in clk cycles (legal >=1).
REQ-003 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request a transfer; sampled only in IDLE.
REQ-006 SHALL provide port line_select  input  2  TX source: 10 command_in, 01 fifo_data, 00 last data_out, 11 all-ones.
REQ-007 SHALL provide ports command_in and fifo_data  input  DATA_W  TX candidate words.
REQ-008 SHALL provide port lsb_first  input  1  bit order, sampled with start (0 = MSB first).
REQ-009 SHALL provide port crc_clr  input  1  clear CRC7 accumulator.
REQ-010 SHALL provide port sddi  input  1  serial data from card.
REQ-011 SHALL provide port sclk  output  1  generated SPI clock, mode 0.
REQ-012 SHALL provide port sddo  output  1  serial data to card.
REQ-013 SHALL provide port busy  output  1  transfer in progress.
REQ-014 SHALL provide port done  output  1  one-cycle pulse, transfer complete.
REQ-015 SHALL provide port data_out  output  DATA_W  last received word.
REQ-016 SHALL provide port crc7  output  7  CRC7 of transmitted bits since last clear.

Function
REQ-017 SHALL implement states IDLE, LOW, HIGH, DONE; IDLE->LOW on start, LOW->HIGH and HIGH->LOW after CLK_DIV cycles each, HIGH->DONE after bit DATA_W, DONE->IDLE unconditionally.
REQ-018 SHALL, on accepting start, load the TX shift register from the line_select source and latch lsb_first in the same edge; busy=1 from the next cycle.
REQ-019 SHALL hold sclk=0 in LOW, sclk=1 in HIGH, sclk=0 in IDLE and DONE.
REQ-020 SHALL drive sddo with the current TX bit throughout LOW and HIGH; sddo=1 in IDLE and DONE.
REQ-021 SHALL sample sddi on the clk edge entering HIGH and advance the TX bit on the edge leaving HIGH.
REQ-022 SHALL maintain a bit counter 0..DATA_W-1; no wrap beyond DATA_W-1.
REQ-023 SHALL assemble received bits in the latched order so data_out matches TX bit significance.
REQ-024 SHALL update data_out and assert done for exactly the DONE cycle; busy=0 in DONE.
REQ-025 SHALL give start-accept to done latency of 2*CLK_DIV*DATA_W+1 clk cycles.
REQ-026 SHALL ignore start while not in IDLE; no queuing.
REQ-027 SHALL accept start in the cycle after DONE (back-to-back, one IDLE cycle minimum).
REQ-028 SHALL, for line_select 00, transmit the data_out value present at start acceptance.

Reset
REQ-029 SHALL on rst force IDLE, sclk=0, sddo=1, busy=0, done=0, data_out=0, crc7=0, counters 0.
REQ-030 SHALL abort any transfer when rst asserts mid-operation; no done pulse, data_out=0.
REQ-031 SHALL give rst priority over start and crc_clr in the same cycle.

Configuration
REQ-032 SHALL compile CRC7 logic only when macro SPI_SHIFT_CRC7_EN is defined.
REQ-033 SHALL, with SPI_SHIFT_CRC7_EN, update crc7 (poly x^7+x^3+1, init 0) once per transmitted bit on the edge leaving HIGH; crc_clr zeroes it, crc_clr wins over a simultaneous update.
REQ-034 SHALL, without SPI_SHIFT_CRC7_EN, tie crc7 to 0 and ignore crc_clr; all other behaviour unchanged.

Verification
REQ-035 SHALL cover: DATA_W=8, CLK_DIV=4, line_select=10, command_in=0x40, sddi looped to sddo -> done after 65 cycles, data_out=0x40.
REQ-036 SHALL cover: line_select=01, fifo_data=0xA5, lsb_first=1, sddi driven 0x3C LSB first -> sddo sequence 1,0,1,0,0,1,0,1, data_out=0x3C.
REQ-037 SHALL cover: start re-pulsed during busy, then start in cycle after done -> first ignored, second accepted, exactly two done pulses.
REQ-038 SHALL cover: rst asserted at bit 4 -> next cycle sclk=0, sddo=1, busy=0, data_out=0, no done.
REQ-039 SHALL cover (SPI_SHIFT_CRC7_EN): crc_clr, then transmit 0x40,0x00,0x00,0x00,0x00 -> crc7=0x4A; without macro crc7=0.
REQ-040 SHALL cover: line_select=11 -> sddo=1 all 8 bits; line_select=00 after prior data_out=0x5A -> transmits 0x5A.
